// File: rtl/posit_construction.sv
// posit_construction: two-stage posit encoder with round-to-nearest-even and valid/ready flow control
module posit_construction #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                Sign,
  input  logic signed [RS+2:0] k,
  input  logic [ES-1:0]       Exponent,
  input  logic [N-1:0]        Mantissa,
  input  logic                inf,
  input  logic                zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        Out
);
  localparam int W = 2*N+ES;
  localparam logic [N-2:0] MAXPOS = '1;
  localparam logic [N-2:0] MINPOS = (N-1)'(1);
  localparam logic signed [RS+2:0] KMAX = (RS+3)'(N-2);
  localparam logic signed [RS+2:0] KMIN = -KMAX;
  logic advance;
  logic [RS+2:0] sh;
  logic [W-1:0] pat, vec;
  logic [N-2:0] kept, rnd, mag_d, mag_q;
  logic guard, sticky;
  logic [N-1:0] sum, out_d, out_q;
  logic v1_q, sign_q, inf_q, zero_q, out_valid_q;
  logic unused_hidden;
  assign unused_hidden = Mantissa[N-1];
  assign advance = ~out_valid_q | out_ready;
  assign in_ready = advance;
  assign out_valid = out_valid_q;
  assign Out = out_q;
  // stage 1: the regime comes from sign-filling a 10/01 seed, then round to nearest even and saturate
  always_comb begin
    sh = k[RS+2] ? ~k : k;
    pat = {~k[RS+2], k[RS+2], Exponent, Mantissa[N-2:0], {(N-1){1'b0}}};
    vec = $signed(pat) >>> sh;
    kept = vec[W-1 -: N-1];
    guard = vec[W-N];
    sticky = |vec[W-N-1:0];
    sum = {1'b0, kept} + N'(guard & (sticky | kept[0]));
    rnd = sum[N-1] ? MAXPOS : (sum[N-2:0] == '0 ? MINPOS : sum[N-2:0]);
    mag_d = k > KMAX ? MAXPOS : (k < KMIN ? MINPOS : rnd);
  end
  // stage 2: apply specials (NaR wins over zero) and the sign as a two's complement
  always_comb begin
    out_d = inf_q ? {1'b1, {(N-1){1'b0}}} : (zero_q ? '0 : (sign_q ? -{1'b0, mag_q} : {1'b0, mag_q}));
  end
  // both stages advance together whenever the output slot is empty or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q <= '0;
      mag_q <= '0;
      sign_q <= 1'b0;
      inf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      out_valid_q <= v1_q;
      if (in_valid) {sign_q, inf_q, zero_q, mag_q} <= {Sign, inf, zero, mag_d};
      if (v1_q) out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_posit_construction.sv
// tb_posit_construction: scoreboard bench for the posit encoder at N=8/ES=3 and N=16/ES=1
module tb_posit_construction;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic iv8 = 1'b0, ir8, s8 = 1'b0, inf8 = 1'b0, z8 = 1'b0, ov8, or8 = 1'b1;
  logic signed [5:0] k8 = '0;
  logic [2:0] e8 = '0;
  logic [7:0] m8 = '0, out8;
  logic iv16 = 1'b0, ir16, s16 = 1'b0, inf16 = 1'b0, z16 = 1'b0, ov16, or16 = 1'b1;
  logic signed [6:0] k16 = '0;
  logic [0:0] e16 = '0;
  logic [15:0] m16 = '0, out16;
  logic [15:0] q8[$], q16[$];
  logic [15:0] exp8, exp16;
  int nrun = 0, nfail = 0, cyc = 0, c0;

  posit_construction #(.N(8), .ES(3)) d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .Sign(s8), .k(k8),
    .Exponent(e8), .Mantissa(m8), .inf(inf8), .zero(z8),
    .out_valid(ov8), .out_ready(or8), .Out(out8));

  posit_construction #(.N(16), .ES(1)) d16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .Sign(s16), .k(k16),
    .Exponent(e16), .Mantissa(m16), .inf(inf16), .zero(z16),
    .out_valid(ov16), .out_ready(or16), .Out(out16));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    nrun++;
    nfail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // reference: append regime/exponent/fraction bit by bit, then round the tail
  function automatic logic [15:0] model(int n, int es, bit s, int k, int e, int m, bit nar, bit zr);
    logic [63:0] str = '0;
    int len = 0;
    int mx = (1 << (n-1)) - 1;
    int mag;
    bit g, st;
    if (nar) return 16'(1 << (n-1));
    if (zr) return 16'(0);
    if (k > n-2) mag = mx;
    else if (k < 2-n) mag = 1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin str[63-len] = 1'b1; len++; end
        len++;
      end else begin
        len = -k;
        str[63-len] = 1'b1;
        len++;
      end
      for (int i = es-1; i >= 0; i--) begin str[63-len] = e[i]; len++; end
      for (int i = n-2; i >= 0; i--) begin str[63-len] = m[i]; len++; end
      mag = int'(str >> (65-n));
      g = str[64-n];
      st = (str << n) != 64'd0;
      if (g && (st || mag[0])) mag++;
      if (mag > mx) mag = mx;
      if (mag == 0) mag = 1;
    end
    return 16'(s ? (((1 << n) - mag) & ((1 << n) - 1)) : mag);
  endfunction

  task automatic send8(bit s, int k, int e, int m, bit nar, bit zr, logic [15:0] exp);
    int t = 0;
    @(negedge clk);
    s8 = s; k8 = 6'(k); e8 = 3'(e); m8 = 8'(m); inf8 = nar; z8 = zr; iv8 = 1'b1;
    q8.push_back(exp);
    while (!ir8 && t < 50) begin @(negedge clk); t++; end
    if (t == 50) timeout("accept8");
  endtask

  task automatic send16(bit s, int k, int e, int m, bit nar, bit zr, logic [15:0] exp);
    int t = 0;
    @(negedge clk);
    s16 = s; k16 = 7'(k); e16 = 1'(e); m16 = 16'(m); inf16 = nar; z16 = zr; iv16 = 1'b1;
    q16.push_back(exp);
    while (!ir16 && t < 50) begin @(negedge clk); t++; end
    if (t == 50) timeout("accept16");
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    iv8 = 1'b0;
    iv16 = 1'b0;
    while ((q8.size() != 0 || q16.size() != 0) && t < 100) begin @(negedge clk); t++; end
    if (t == 100) timeout("drain");
  endtask

  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) begin
        nrun++; nfail++;
        $display("FAIL out8_unexpected: got %h expected no output", out8);
      end else begin
        exp8 = q8.pop_front();
        check("out8", 16'(out8), exp8);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) begin
        nrun++; nfail++;
        $display("FAIL out16_unexpected: got %h expected no output", out16);
      end else begin
        exp16 = q16.pop_front();
        check("out16", out16, exp16);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, nar, zr;
    int k, e, m;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 16'(ov8), 16'h0);
    check("reset_out", 16'(out8), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 16'(ir8), 16'h1);
    send8(0, 0, 0, 'h80, 0, 0, 16'h40);
    @(negedge clk);
    iv8 = 1'b0;
    check("latency_not_early", 16'(ov8), 16'h0);
    @(negedge clk);
    check("latency_two", 16'(ov8), 16'h1);
    send8(1, 0, 0, 'h80, 0, 0, 16'hC0);
    send8(0, 0, 0, 'hB0, 0, 0, 16'h42);
    send8(0, 0, 0, 'h90, 0, 0, 16'h40);
    send8(0, 0, 7, 'hF0, 0, 0, 16'h60);
    send8(0, 3, 5, 'hA5, 0, 1, 16'h00);
    send8(1, 0, 0, 'h80, 1, 1, 16'h80);
    send8(0, 7, 0, 'h80, 0, 0, 16'h7F);
    send8(0, -7, 0, 'h80, 0, 0, 16'h01);
    send8(0, -6, 0, 'h80, 0, 0, 16'h01);
    send8(1, 7, 0, 'h80, 0, 0, 16'h81);
    send8(0, -1, 0, 'h80, 0, 0, 16'h20);
    send8(0, 6, 5, 'hFF, 0, 0, 16'h7F);
    send8(0, 5, 4, 'h80, 0, 0, 16'h7E);
    send8(0, 5, 4, 'h81, 0, 0, 16'h7F);
    send8(0, -5, 7, 'h80, 0, 0, 16'h04);
    send8(1, -5, 7, 'h80, 0, 0, 16'hFC);
    drain();
    fork
      begin
        send8(0, 0, 0, 'h80, 0, 0, 16'h40);
        send8(0, 0, 0, 'hB0, 0, 0, 16'h42);
        send8(0, 0, 7, 'hF0, 0, 0, 16'h60);
        send8(1, 0, 0, 'h80, 0, 0, 16'hC0);
        @(negedge clk);
        iv8 = 1'b0;
      end
      begin
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!ov8 && t < 50);
        if (t == 50) timeout("first_output");
        @(posedge clk);
        #1 or8 = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 16'(ir8), 16'h0);
          check("stall_out_stable", 16'(out8), 16'h42);
          check("stall_out_valid", 16'(ov8), 16'h1);
        end
        @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1 or8 = 1'b0;
    send8(0, 0, 0, 'h80, 0, 0, 16'h40);
    send8(0, 0, 7, 'hF0, 0, 0, 16'h60);
    @(negedge clk);
    iv8 = 1'b0;
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    check("midreset_out_valid", 16'(ov8), 16'h0);
    check("midreset_out", 16'(out8), 16'h0);
    rst = 1'b0;
    @(posedge clk);
    #1 or8 = 1'b1;
    repeat (6) @(negedge clk);
    check("midreset_in_ready", 16'(ir8), 16'h1);
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(1));
      k = int'($urandom_range(16)) - 8;
      e = int'($urandom_range(7));
      m = int'($urandom_range(127)) | 'h80;
      nar = ($urandom_range(15) == 0);
      zr = ($urandom_range(15) == 0);
      send8(s, k, e, m, nar, zr, model(8, 3, s, k, e, m, nar, zr));
      if (i == 0) c0 = cyc;
    end
    check("throughput8_cycles", 16'(cyc - c0), 16'd29);
    drain();
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(1));
      k = int'($urandom_range(34)) - 17;
      e = int'($urandom_range(1));
      m = int'($urandom_range(32767)) | 'h8000;
      nar = ($urandom_range(15) == 0);
      zr = ($urandom_range(15) == 0);
      send16(s, k, e, m, nar, zr, model(16, 1, s, k, e, m, nar, zr));
      if (i == 0) c0 = cyc;
    end
    check("throughput16_cycles", 16'(cyc - c0), 16'd29);
    send16(0, 0, 0, 'h8000, 0, 0, 16'h4000);
    send16(1, 14, 1, 'hFFFF, 0, 0, 16'h8001);
    send16(0, -15, 0, 'h8000, 0, 0, 16'h0001);
    drain();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
